// File: rtl/vga_capture_rx_if.sv
// VGA capture link: incoming sync/colour pins and the recovered pixel stream.
// master = video source / pixel sink side, slave = vga_capture_rx.
interface vga_capture_rx_if;
    logic       hsync_in;
    logic       vsync_in;
    logic [2:0] rgb_in;
    logic       pix_valid;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [2:0] pix_rgb;
    logic       frame_start;
    logic       locked;
    logic       sync_err;

    modport master (
        output hsync_in, vsync_in, rgb_in,
        input  pix_valid, pix_x, pix_y, pix_rgb,
        input  frame_start, locked, sync_err
    );

    modport slave (
        input  hsync_in, vsync_in, rgb_in,
        output pix_valid, pix_x, pix_y, pix_rgb,
        output frame_start, locked, sync_err
    );
endinterface

// File: rtl/vga_capture_rx.sv
// VGA receiver: recovers x/y from sync edges, checks 800x525 timing, and
// emits per-pixel write strobes once locked. Optional macro:
// VGA_CAPTURE_BGR_SWAP_EN swaps red/blue on pix_rgb.
// Ports: clk, rst (async, active high); vif.slave carries hsync_in,
// vsync_in, rgb_in in and pix_valid, pix_x, pix_y, pix_rgb, frame_start,
// locked, sync_err out.
module vga_capture_rx #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input logic             clk,
    input logic             rst,
    vga_capture_rx_if.slave vif
);
    localparam logic [9:0] HS_X  = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] VS_Y  = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] H_END = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_END = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
    localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH,
        ACQUIRE,
        LOCKED
    } state_t;

    state_t     state;
    logic       hs_q, hs_d, vs_q, vs_d;
    logic [2:0] rgb_q;
    logic [9:0] hcnt, vcnt;
    logic [3:0] good;

    logic       pix_valid_r, frame_start_r, locked_r, sync_err_r;
    logic [9:0] pix_x_r, pix_y_r;
    logic [2:0] pix_rgb_r;

    logic       hfall, vfall, tracking, h_exp, v_exp;
    logic       mismatch, active;
    logic [9:0] cur_h, cur_v, nxt_h, nxt_v;
    logic [2:0] rgb_map;

    // In SEARCH the counters are idle, so the VSYNC fall sample takes its
    // coordinate (0, V_ACTIVE+V_FRONT) directly instead of from hcnt/vcnt.
    always_comb begin
        hfall    = !hs_q && hs_d;
        vfall    = !vs_q && vs_d;
        tracking = (state != SEARCH);
        cur_h    = hcnt;
        cur_v    = vcnt;
        if (!tracking && vfall) begin
            cur_h = '0;
            cur_v = VS_Y;
        end
        h_exp    = (cur_h == HS_X);
        v_exp    = (cur_h == '0) && (cur_v == VS_Y);
        mismatch = tracking && ((hfall != h_exp) || (vfall != v_exp));
        active   = (state == LOCKED) && (cur_h < H_ACT) && (cur_v < V_ACT);
        nxt_h    = cur_h + 10'd1;
        nxt_v    = cur_v;
        if (cur_h == H_END) begin
            nxt_h = '0;
            nxt_v = (cur_v == V_END) ? '0 : cur_v + 10'd1;
        end
    end

`ifdef VGA_CAPTURE_BGR_SWAP_EN
    assign rgb_map = {rgb_q[0], rgb_q[1], rgb_q[2]};
`else
    assign rgb_map = rgb_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= SEARCH;
            hs_q          <= 1'b1;
            hs_d          <= 1'b1;
            vs_q          <= 1'b1;
            vs_d          <= 1'b1;
            rgb_q         <= '0;
            hcnt          <= '0;
            vcnt          <= '0;
            good          <= '0;
            pix_valid_r   <= 1'b0;
            frame_start_r <= 1'b0;
            locked_r      <= 1'b0;
            sync_err_r    <= 1'b0;
            pix_x_r       <= '0;
            pix_y_r       <= '0;
            pix_rgb_r     <= '0;
        end else begin
            hs_q          <= vif.hsync_in;
            vs_q          <= vif.vsync_in;
            rgb_q         <= vif.rgb_in;
            hs_d          <= hs_q;
            vs_d          <= vs_q;
            pix_x_r       <= cur_h;
            pix_y_r       <= cur_v;
            pix_rgb_r     <= rgb_map;
            pix_valid_r   <= active;
            frame_start_r <= active && (cur_h == '0) && (cur_v == '0);
            sync_err_r    <= 1'b0;
            unique case (state)
                SEARCH: begin
                    if (vfall) begin
                        good  <= '0;
                        hcnt  <= nxt_h;
                        vcnt  <= nxt_v;
                        state <= ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (mismatch) begin
                        hcnt  <= '0;
                        vcnt  <= '0;
                        state <= SEARCH;
                    end else begin
                        hcnt <= nxt_h;
                        vcnt <= nxt_v;
                        if (v_exp) begin
                            good <= good + 4'd1;
                            if (good + 4'd1 == LOCK_N) begin
                                state    <= LOCKED;
                                locked_r <= 1'b1;
                            end
                        end
                    end
                end
                LOCKED: begin
                    if (mismatch) begin
                        hcnt       <= '0;
                        vcnt       <= '0;
                        sync_err_r <= 1'b1;
                        locked_r   <= 1'b0;
                        state      <= SEARCH;
                    end else begin
                        hcnt <= nxt_h;
                        vcnt <= nxt_v;
                    end
                end
                default: begin
                    state    <= SEARCH;
                    locked_r <= 1'b0;
                end
            endcase
        end
    end

    assign vif.pix_valid   = pix_valid_r;
    assign vif.pix_x       = pix_x_r;
    assign vif.pix_y       = pix_y_r;
    assign vif.pix_rgb     = pix_rgb_r;
    assign vif.frame_start = frame_start_r;
    assign vif.locked      = locked_r;
    assign vif.sync_err    = sync_err_r;
endmodule
